// File: rtl/pipelined_cla_adder.sv
// ---------------------------------------------------------------------------
// pipelined_cla_adder
//
// Purpose:
//   WIDTH-bit adder/subtractor built from BLOCK-bit carry-lookahead groups.
//   Group k is resolved in pipeline stage k using the carry registered by
//   stage k-1, so a result emerges after STAGES = WIDTH/BLOCK cycles.
//   Stages advance together; a single stall (final result not taken) freezes
//   the whole pipe, so bubbles keep their position.
//
// Ports:
//   clk        clock, rising-edge active
//   rst_n      asynchronous active-low reset (clears valid bits / outputs)
//   in_valid   operand set on A/B/cin/sub is presented
//   in_ready   operands are accepted this cycle (low only while stalled)
//   A, B       WIDTH-bit operands (unsigned or two's complement)
//   cin        carry-in (add) or borrow-in (subtract)
//   sub        0 = A + B + cin, 1 = A - B - cin
//   out_valid  sum/cout/ovf hold a valid result
//   out_ready  downstream takes the result this cycle
//   sum        WIDTH-bit result
//   cout       carry-out (add) or not-borrow (subtract)
//   ovf        signed two's-complement overflow
// ---------------------------------------------------------------------------
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / BLOCK;
    localparam int LAST   = STAGES - 1;

    // One lookahead group: every carry is a flat sum of products of the
    // group's generate/propagate terms and the group carry-in, so no carry
    // depends on another carry inside the group. Returns {carry_out, sum}.
    function automatic logic [BLOCK:0] cla_group(
        input logic [BLOCK-1:0] a,
        input logic [BLOCK-1:0] b,
        input logic             c0
    );
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        logic             term;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < BLOCK; i++) begin
            term = c0;
            for (int m = 0; m <= i; m++) begin
                term = term & p[m];
            end
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                c[i+1] = c[i+1] | term;
            end
        end
        return {c[BLOCK], p ^ c[BLOCK-1:0]};
    endfunction

    // Pipeline registers: index k holds what stage k produced.
    logic signed [WIDTH-1:0] a_p   [STAGES];
    logic signed [WIDTH-1:0] b_p   [STAGES];
    logic        [WIDTH-1:0] sum_p [STAGES];
    logic        [STAGES-1:0] vld_p;
    logic        [STAGES-1:0] c_p;
    logic        [STAGES-1:0] ss_p;   // effective operand signs match
    logic        [STAGES-1:0] sa_p;   // sign of A

    // Stage inputs and next-state values.
    logic signed [WIDTH-1:0] a_in  [STAGES];
    logic signed [WIDTH-1:0] b_in  [STAGES];
    logic        [WIDTH-1:0] base  [STAGES];
    logic        [WIDTH-1:0] nsum  [STAGES];
    logic        [BLOCK:0]   grp   [STAGES];
    logic        [STAGES-1:0] vld_in;
    logic        [STAGES-1:0] c_in;
    logic        [STAGES-1:0] ss_in;
    logic        [STAGES-1:0] sa_in;
    logic        [STAGES-1:0] ncar;

    logic             stall;
    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // Subtraction is A + ~B + ~cin, so borrow-in becomes an inverted carry.
    assign b_eff = sub ? ~B : B;
    assign c_eff = sub ? ~cin : cin;

    // in_ready depends only on the final stage and out_ready.
    assign stall    = vld_p[LAST] & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = adv;

    always_comb begin
        a_in[0]   = A;
        b_in[0]   = b_eff;
        c_in[0]   = c_eff;
        vld_in[0] = in_valid;
        ss_in[0]  = ~(A[WIDTH-1] ^ b_eff[WIDTH-1]);
        sa_in[0]  = A[WIDTH-1];
        base[0]   = '0;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k]   = a_p[k-1];
            b_in[k]   = b_p[k-1];
            c_in[k]   = c_p[k-1];
            vld_in[k] = vld_p[k-1];
            ss_in[k]  = ss_p[k-1];
            sa_in[k]  = sa_p[k-1];
            base[k]   = sum_p[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            grp[k]  = cla_group(a_in[k][k*BLOCK +: BLOCK],
                                b_in[k][k*BLOCK +: BLOCK], c_in[k]);
            nsum[k] = base[k];
            nsum[k][k*BLOCK +: BLOCK] = grp[k][BLOCK-1:0];
            ncar[k] = grp[k][BLOCK];
        end
    end

    // ---- stage boundary: valid bits (control, reset) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else if (adv) begin
            vld_p <= vld_in;
        end
    end

    // ---- stage boundary: datapath registers (no reset) ----
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_p[k]   <= a_in[k];
                b_p[k]   <= b_in[k];
                sum_p[k] <= nsum[k];
            end
            c_p  <= ncar;
            ss_p <= ss_in;
            sa_p <= sa_in;
        end
    end

    // Outputs are gated by the final valid bit so reset forces them to zero
    // without resetting the datapath registers.
    assign out_valid = vld_p[LAST];
    assign sum       = out_valid ? sum_p[LAST] : '0;
    assign cout      = out_valid & c_p[LAST];
    assign ovf       = out_valid & ss_p[LAST] & (sum_p[LAST][WIDTH-1] ^ sa_p[LAST]);

endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int nchecks = 0;
    int nerr    = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t tbl [12];
    vec_t vq  [$];

    pipelined_cla_adder #(.WIDTH(16), .BLOCK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Plain arithmetic reference for randomly generated operations.
    function automatic vec_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic c, input logic s);
        vec_t        v;
        logic [15:0] be;
        logic        ce;
        logic [16:0] r;
        be     = s ? ~b : b;
        ce     = s ? ~c : c;
        r      = {1'b0, a} + {1'b0, be} + {16'b0, ce};
        v.a    = a;
        v.b    = b;
        v.cin  = c;
        v.sub  = s;
        v.sum  = r[15:0];
        v.cout = r[16];
        v.ovf  = (a[15] == be[15]) && (r[15] != a[15]);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        A   = v.a;
        B   = v.b;
        cin = v.cin;
        sub = v.sub;
    endtask

    // Streams the n entries of vq back-to-back and checks results in order.
    // With stall_len > 0, out_ready drops for stall_len cycles as soon as the
    // first result is visible.
    task automatic run_ops(input int n, input int stall_len, input string tag);
        int          ii = 0;
        int          oo = 0;
        int          cyc = 0;
        int          stall_left = 0;
        bit          started = 0;
        logic [15:0] fs;
        logic        fc;
        logic        fo;
        fs = '0;
        fc = 1'b0;
        fo = 1'b0;
        while (oo < n && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (stall_len > 0 && !started && out_valid) begin
                started    = 1;
                stall_left = stall_len;
                fs = sum;
                fc = cout;
                fo = ovf;
            end
            out_ready = (stall_left > 0) ? 1'b0 : 1'b1;
            if (ii < n) begin
                in_valid = 1'b1;
                drive(vq[ii]);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stall_left > 0) begin
                chk({tag, " stall in_ready"}, {31'b0, in_ready}, 32'd0);
                chk({tag, " stall out_valid"}, {31'b0, out_valid}, 32'd1);
                chk({tag, " stall sum frozen"}, {16'b0, sum}, {16'b0, fs});
                chk({tag, " stall cout/ovf frozen"}, {30'b0, cout, ovf}, {30'b0, fc, fo});
                stall_left--;
            end
            if (out_valid && out_ready) begin
                chk($sformatf("%s sum[%0d]", tag, oo), {16'b0, sum}, {16'b0, vq[oo].sum});
                chk($sformatf("%s cout[%0d]", tag, oo), {31'b0, cout}, {31'b0, vq[oo].cout});
                chk($sformatf("%s ovf[%0d]", tag, oo), {31'b0, ovf}, {31'b0, vq[oo].ovf});
                oo++;
            end
            if (in_valid && in_ready) ii++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({tag, " results received"}, oo, n);
        if (stall_len > 0) chk({tag, " stall happened"}, {31'b0, started}, 32'd1);
        // Nothing extra may follow the last result.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk({tag, " no extra result"}, {31'b0, out_valid}, 32'd0);
        end
    endtask

    initial begin
        int lat;

        tbl[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[3]  = '{16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0};
        tbl[4]  = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
        tbl[5]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[6]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[7]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        tbl[8]  = '{16'h0FFF, 16'h0001, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};
        tbl[9]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[10] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[11] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A = '0; B = '0; cin = 1'b0; sub = 1'b0;

        // Asynchronous reset, before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset sum", {16'b0, sum}, 32'h0);
        chk("reset cout", {31'b0, cout}, 32'd0);
        chk("reset ovf", {31'b0, ovf}, 32'd0);
        chk("reset in_ready", {31'b0, in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed table, one operation at a time, with latency measurement.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            drive(tbl[i]);
            #1;
            chk($sformatf("tbl in_ready[%0d]", i), {31'b0, in_ready}, 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            chk($sformatf("tbl latency[%0d]", i), lat, 4);
            chk($sformatf("tbl sum[%0d]", i), {16'b0, sum}, {16'b0, tbl[i].sum});
            chk($sformatf("tbl cout[%0d]", i), {31'b0, cout}, {31'b0, tbl[i].cout});
            chk($sformatf("tbl ovf[%0d]", i), {31'b0, ovf}, {31'b0, tbl[i].ovf});
        end

        // Same table streamed back-to-back: one result per cycle, in order.
        vq.delete();
        for (int i = 0; i < 12; i++) vq.push_back(tbl[i]);
        run_ops(12, 0, "stream");

        // Eight random operations with a 3-cycle stall on the first result.
        vq.delete();
        for (int i = 0; i < 8; i++)
            vq.push_back(model(16'($urandom), 16'($urandom),
                               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
        run_ops(8, 3, "bp");

        // Reset while three operations are in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            drive(model(16'h1111 * 16'(i + 1), 16'h0101, 1'b0, 1'b0));
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("midflight before reset", {31'b0, out_valid}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("midflight reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("midflight reset in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("midflight discarded %0d", i), {31'b0, out_valid}, 32'd0);
        end
        vq.delete();
        vq.push_back(tbl[4]);
        run_ops(1, 0, "after reset");

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", nchecks, nerr);
        $fatal(1, "timeout");
    end

endmodule
